// File: rtl/csr_pkg.sv
// Shared op and FSM encodings for the CSR bank.
// Optional build macro used by the bank: CSR_CYCLE_COUNTER_EN.
package csr_pkg;

   typedef enum logic [1:0] {
      CSR_OP_READ  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_e;

   typedef enum logic {
      CSR_IDLE = 1'b0,
      CSR_RESP = 1'b1
   } csr_state_e;

endpackage

// File: rtl/csr_bank_if.sv
// Request/ack bus and debug read port of the CSR bank.
interface csr_bank_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 4
);
   logic             I_req;
   logic [1:0]       I_op;
   logic [AW-1:0]    I_addr;
   logic [WIDTH-1:0] I_wdata;
   logic             O_ack;
   logic [WIDTH-1:0] O_rdata;
   logic             O_illegal;
   logic [AW-1:0]    I_dbg_addr;
   logic [WIDTH-1:0] O_dbg_data;

   modport master (
      output I_req, I_op, I_addr, I_wdata, I_dbg_addr,
      input  O_ack, O_rdata, O_illegal, O_dbg_data
   );

   modport slave (
      input  I_req, I_op, I_addr, I_wdata, I_dbg_addr,
      output O_ack, O_rdata, O_illegal, O_dbg_data
   );
endinterface

// File: rtl/csr_rmw.sv
// Combinational read-modify-write: new entry value, write enable and
// read-only violation for one CSR op.
module csr_rmw
   import csr_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] old_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             ro_i,
   output logic [WIDTH-1:0] new_o,
   output logic             wr_o,
   output logic             ro_viol_o
);
   always_comb begin
      new_o     = old_i;
      wr_o      = 1'b0;
      ro_viol_o = 1'b0;
      case (csr_op_e'(op_i))
         CSR_OP_WRITE: new_o = wdata_i;
         CSR_OP_SET:   new_o = old_i | wdata_i;
         CSR_OP_CLEAR: new_o = old_i & ~wdata_i;
         default:      new_o = old_i;
      endcase
      if (csr_op_e'(op_i) != CSR_OP_READ) begin
         wr_o = !ro_i;
         // a zero mask on a read-only entry degenerates to a plain read
         ro_viol_o = ro_i && ((csr_op_e'(op_i) == CSR_OP_WRITE) || (wdata_i != '0));
      end
   end
endmodule

// File: rtl/csr_bank.sv
// Parametrised CSR bank with write/set/clear ops, req/ack handshake and a
// combinational debug read port. CSR_CYCLE_COUNTER_EN makes entry 0 a cycle counter.
module csr_bank
   import csr_pkg::*;
#(
   parameter int               WIDTH   = 32,
   parameter int               DEPTH   = 16,
   parameter int               AW      = 4,
   parameter logic [DEPTH-1:0] RO_MASK = '0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input logic       I_clk,
   input logic       I_rst,
   csr_bank_if.slave bus
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] view [DEPTH];
   logic [DEPTH-1:0] ro_vec;

   csr_state_e       state_q;
   logic             ack_q, ill_q, upd_q;
   logic [WIDTH-1:0] rdata_q, nv_q;
   logic [AW-1:0]    addr_q;

   logic [WIDTH-1:0] sel_old, dbg_d, nv_d;
   logic             sel_ro, addr_ok, wr_d, viol_d, ill_d, upd_d;

`ifdef CSR_CYCLE_COUNTER_EN
   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) cnt_q <= '0;
      else       cnt_q <= cnt_q + WIDTH'(1);
   end
`endif

   // architectural view of every entry, with entry 0 overridden
   always_comb begin
      for (int i = 0; i < DEPTH; i++) view[i] = mem_q[i];
      ro_vec = RO_MASK;
`ifdef CSR_CYCLE_COUNTER_EN
      view[0]   = cnt_q;
      ro_vec[0] = 1'b1;
`else
      view[0] = '0;
`endif
   end

   always_comb begin
      sel_old = '0;
      sel_ro  = 1'b0;
      addr_ok = 1'b0;
      dbg_d   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.I_addr == AW'(i)) begin
            addr_ok = 1'b1;
            sel_old = view[i];
            sel_ro  = ro_vec[i];
         end
         if (bus.I_dbg_addr == AW'(i)) dbg_d = view[i];
      end
   end

   csr_rmw #(.WIDTH(WIDTH)) u_rmw (
      .op_i      (bus.I_op),
      .old_i     (sel_old),
      .wdata_i   (bus.I_wdata),
      .ro_i      (sel_ro),
      .new_o     (nv_d),
      .wr_o      (wr_d),
      .ro_viol_o (viol_d)
   );

   assign ill_d = !addr_ok || viol_d;
   // entry 0 is never stored: counter or constant zero
   assign upd_d = !ill_d && wr_d && (bus.I_addr != '0);

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q <= CSR_IDLE;
         ack_q   <= 1'b0;
         ill_q   <= 1'b0;
         upd_q   <= 1'b0;
         rdata_q <= '0;
         nv_q    <= '0;
         addr_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
      end else begin
         case (state_q)
            CSR_IDLE: begin
               if (bus.I_req) begin
                  state_q <= CSR_RESP;
                  ack_q   <= 1'b1;
                  ill_q   <= ill_d;
                  rdata_q <= ill_d ? '0 : sel_old;
                  upd_q   <= upd_d;
                  nv_q    <= nv_d;
                  addr_q  <= bus.I_addr;
               end
            end
            CSR_RESP: begin
               state_q <= CSR_IDLE;
               ack_q   <= 1'b0;
               ill_q   <= 1'b0;
               rdata_q <= '0;
               upd_q   <= 1'b0;
               for (int i = 0; i < DEPTH; i++)
                  if (upd_q && addr_q == AW'(i)) mem_q[i] <= nv_q;
            end
            default: state_q <= CSR_IDLE;
         endcase
      end
   end

   assign bus.O_ack      = ack_q;
   assign bus.O_illegal  = ill_q;
   assign bus.O_rdata    = rdata_q;
   assign bus.O_dbg_data = dbg_d;
endmodule

// File: tb/tb_csr_bank.sv
// Randomised bench for csr_bank with a spec-level reference model and
// directed literal checks; counter checks compile when CSR_CYCLE_COUNTER_EN is set.
module tb_csr_bank;
   import csr_pkg::*;

   localparam int          W   = 32;
   localparam int          D   = 16;
   localparam int          A   = 5;
   localparam logic [15:0] ROM = 16'h0020;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   csr_bank_if #(.WIDTH(W), .AW(A)) bus ();

   csr_bank #(.WIDTH(W), .DEPTH(D), .AW(A), .RO_MASK(ROM), .RST_VAL('0)) dut (
      .I_clk (clk),
      .I_rst (rst),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] mem_m [D];
   logic [31:0] cnt_m;
   bit          pend, pend_upd, exp_ack, exp_ill;
   logic [31:0] exp_rd, pend_val, mwd, mold;
   int          pend_addr, ma;
   logic [1:0]  mop;
   bit          mlegal;

   function automatic bit ro_m(input int a);
`ifdef CSR_CYCLE_COUNTER_EN
      if (a == 0) return 1'b1;
`endif
      return ROM[a];
   endfunction

   function automatic logic [31:0] view_m(input int a);
      if (a >= D) return 32'h0;
      if (a == 0) begin
`ifdef CSR_CYCLE_COUNTER_EN
         return cnt_m;
`else
         return 32'h0;
`endif
      end
      return mem_m[a];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < D; i++) mem_m[i] = '0;
         cnt_m = '0; pend = 0; exp_ack = 0; exp_ill = 0; exp_rd = '0;
      end else begin
         if (pend) begin
            if (pend_upd) mem_m[pend_addr] = pend_val;
            pend = 0; exp_ack = 0;
         end else if (bus.I_req) begin
            ma = int'(bus.I_addr); mop = bus.I_op; mwd = bus.I_wdata;
            mlegal = (ma < D) && !(ro_m(ma) && (mop == 2'b01 || (mop != 2'b00 && mwd != 0)));
            mold = view_m(ma);
            exp_ack = 1; exp_ill = !mlegal; exp_rd = mlegal ? mold : 32'h0;
            pend = 1; pend_addr = ma;
            pend_upd = mlegal && ma != 0 && !ro_m(ma) && mop != 2'b00;
            case (mop)
               2'b01:   pend_val = mwd;
               2'b10:   pend_val = mold | mwd;
               2'b11:   pend_val = mold & ~mwd;
               default: pend_val = mold;
            endcase
         end else exp_ack = 0;
         cnt_m = cnt_m + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst && chk_en) begin
         chk("sb_ack", 32'(bus.O_ack), 32'(exp_ack));
         if (exp_ack) begin
            chk("sb_rdata", bus.O_rdata, exp_rd);
            chk("sb_illegal", 32'(bus.O_illegal), 32'(exp_ill));
         end
         chk("sb_dbg", bus.O_dbg_data, view_m(int'(bus.I_dbg_addr)));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic do_req(input string nm, input logic [1:0] op, input int a, input logic [31:0] wd,
                         input bit chk_rd, input logic [31:0] er, input bit ei, output logic [31:0] got);
      @(posedge clk); #2;
      bus.I_req = 1'b1; bus.I_op = op; bus.I_addr = A'(a); bus.I_wdata = wd;
      @(posedge clk); #2;
      bus.I_req = 1'b0;
      @(negedge clk);
      chk({nm, "_ack"}, 32'(bus.O_ack), 32'd1);
      if (chk_rd) chk({nm, "_rdata"}, bus.O_rdata, er);
      chk({nm, "_illegal"}, 32'(bus.O_illegal), 32'(ei));
      got = bus.O_rdata;
   endtask

   task automatic dbg_after_commit(input string nm, input int a, input logic [31:0] ev);
      #1 bus.I_dbg_addr = A'(a);
      @(posedge clk); @(negedge clk);
      chk(nm, bus.O_dbg_data, ev);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] g, r1, r2;
      int nack, consec;
      bit prev;
      bus.I_req = 0; bus.I_op = 0; bus.I_addr = 0; bus.I_wdata = 0; bus.I_dbg_addr = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", 32'(bus.O_ack), 32'd0);
      chk("rst_rdata", bus.O_rdata, 32'd0);
      chk("rst_illegal", 32'(bus.O_illegal), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0; chk_en = 1'b1;

      for (int a = 0; a < D; a++) do_req("rd_all", CSR_OP_READ, a, 32'h0, 1, 32'h0, 0, g);
      do_req("rd_oob", CSR_OP_READ, 16, 32'h0, 1, 32'h0, 1, g);

      do_req("wr3", CSR_OP_WRITE, 3, 32'hDEADBEEF, 1, 32'h0, 0, g);
      do_req("set3", CSR_OP_SET, 3, 32'h000000F0, 1, 32'hDEADBEEF, 0, g);
      do_req("clr3", CSR_OP_CLEAR, 3, 32'h0000000F, 1, 32'hDEADBEFF, 0, g);
      dbg_after_commit("dbg3", 3, 32'hDEADBEF0);

      do_req("wr5_ro", CSR_OP_WRITE, 5, 32'h12345678, 1, 32'h0, 1, g);
      dbg_after_commit("dbg5", 5, 32'h0);
      do_req("set5_zero", CSR_OP_SET, 5, 32'h0, 1, 32'h0, 0, g);

`ifdef CSR_CYCLE_COUNTER_EN
      do_req("wr0", CSR_OP_WRITE, 0, 32'h55, 1, 32'h0, 1, g);
`else
      do_req("wr0", CSR_OP_WRITE, 0, 32'h55, 1, 32'h0, 0, g);
      dbg_after_commit("dbg0", 0, 32'h0);
`endif

      // request held high: one capture every other cycle
      @(posedge clk); #2;
      bus.I_req = 1'b1; bus.I_op = CSR_OP_READ; bus.I_addr = A'(1);
      nack = 0; consec = 0; prev = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.O_ack) begin
            nack++;
            if (prev) consec++;
         end
         prev = bus.O_ack;
      end
      bus.I_req = 1'b0;
      chk("b2b_acks", 32'(nack), 32'd3);
      chk("b2b_consec", 32'(consec), 32'd0);

      // reset lands in the RESP cycle of a write
      @(posedge clk); #2;
      bus.I_req = 1'b1; bus.I_op = CSR_OP_WRITE; bus.I_addr = A'(7); bus.I_wdata = 32'hA5A5A5A5;
      @(posedge clk); #1;
      rst = 1'b1; bus.I_req = 1'b0;
      @(negedge clk);
      chk("rst_resp_ack", 32'(bus.O_ack), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0; bus.I_dbg_addr = A'(7);
      @(negedge clk);
      chk("rst_resp_dbg7", bus.O_dbg_data, 32'h0);
      dbg_after_commit("rst_dbg3", 3, 32'h0);

      repeat (500) begin
         @(posedge clk); #2;
         bus.I_req      = ($urandom_range(0, 2) != 0);
         bus.I_op       = 2'($urandom_range(0, 3));
         bus.I_addr     = A'($urandom_range(0, 19));
         bus.I_wdata    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         bus.I_dbg_addr = A'($urandom_range(0, 19));
      end
      @(posedge clk); #2;
      bus.I_req = 1'b0;
      repeat (3) @(posedge clk);

`ifdef CSR_CYCLE_COUNTER_EN
      chk_en = 1'b0;
      do_req("cnt_rd1", CSR_OP_READ, 0, 32'h0, 0, 32'h0, 0, r1);
      repeat (2) @(posedge clk);
      do_req("cnt_rd2", CSR_OP_READ, 0, 32'h0, 0, 32'h0, 0, r2);
      chk("cnt_delta", r2 - r1, 32'd4);
      do_req("cnt_wr0", CSR_OP_WRITE, 0, 32'h5, 1, 32'h0, 1, g);
      @(posedge clk); @(negedge clk);
      bus.I_dbg_addr = A'(0);
      force dut.cnt_q = '1;
      #1 chk("cnt_force", bus.O_dbg_data, 32'hFFFFFFFF);
      release dut.cnt_q;
      @(negedge clk);
      chk("cnt_wrap", bus.O_dbg_data, 32'h0);
`else
      r1 = '0; r2 = '0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/csr_bank.md
Name: csr_bank

Overview:
- Parametrised machine CSR bank; the next generation of the CPU's status-register file.
- Generalised in depth and width, with RISC-V style atomic read-modify-write ops (write/set/clear), per-entry read-only protection, illegal-access reporting and a req/ack handshake.
- Sits beside the register file; the execute stage drives it for CSR instructions.
- A second, combinational debug read port is provided.

Parameters:
- WIDTH, 32, data width of every entry.
- DEPTH, 16, number of entries; legal addresses are 0..DEPTH-1.
- AW, 4, address width; must satisfy 2**AW >= DEPTH.
- RO_MASK, 16'h0000, bit i set means entry i is read-only (software writes are rejected).
- RST_VAL, 0, reset and initial value of every writable entry.

Ports:
- I_clk  in  1  clock, rising edge.
- I_rst  in  1  asynchronous, active-high reset.
- I_req  in  1  request valid; sampled on the rising edge.
- I_op  in  2  00 READ, 01 WRITE, 10 SET, 11 CLEAR.
- I_addr  in  AW  target entry.
- I_wdata  in  WIDTH  write value (WRITE) or bit mask (SET/CLEAR).
- O_ack  out  1  one-cycle pulse completing a request.
- O_rdata  out  WIDTH  entry value before the op; valid while O_ack=1.
- O_illegal  out  1  qualifies O_ack; request was rejected.
- I_dbg_addr  in  AW  debug read address.
- O_dbg_data  out  WIDTH  combinational read of the entry at I_dbg_addr.

Behaviour:
- Reset (asynchronous, active-high):
  - every writable entry = RST_VAL; O_ack=0, O_illegal=0, O_rdata=0; internal FSM returns to IDLE.
  - A request in flight when reset asserts is dropped: no ack, no update.
- FSM states:
  - IDLE: I_req=1 on an edge captures op/addr/wdata and moves to RESP. Requests with I_req=0 are ignored.
  - RESP: O_ack=1 for exactly one cycle, then back to IDLE. I_req is ignored in RESP.
  - Maximum throughput is one request every 2 cycles; latency from request edge to O_ack is 1 cycle.
- Update rules:
  - The entry update happens on the same edge that leaves RESP.
  - O_rdata is the pre-update value.
  - WRITE: new = wdata. SET: new = old | wdata. CLEAR: new = old & ~wdata. READ: no update.
- Illegal access (O_illegal=1 with O_ack, no update, O_rdata=0) when either:
  - addr >= DEPTH; or
  - the entry is read-only and the op is WRITE, or SET/CLEAR with wdata != 0.
  - SET/CLEAR of a read-only entry with wdata == 0 is a legal read.
- Read-only entries read as their fixed value, RST_VAL.
- Debug port:
  - Address >= DEPTH reads 0.
  - Shows the committed value; the update becomes visible the cycle after the O_ack cycle.

Optional Feature:
- Macro CSR_CYCLE_COUNTER_EN.
- When defined:
  - entry 0 is a free-running WIDTH-bit cycle counter: reset 0, +1 every cycle, wraps from all-ones to 0.
  - Entry 0 is treated as read-only regardless of RO_MASK.
  - O_rdata returns the counter value at the capture edge.
- When undefined: entry 0 reads constant 0 and writes to it are silently dropped (legal, no illegal flag).

Decomposition:
- Shared package `csr_pkg`:
  - op encoding constants (CSR_OP_READ/WRITE/SET/CLEAR);
  - FSM state constants (CSR_IDLE, CSR_RESP).
- One natural sub-module, `csr_rmw`: combinational new-value and legality computation from op, old value, wdata and RO bit.

Test Plan:
- Reset then READ of every address -> O_ack one cycle after the request, O_rdata=0, O_illegal=0; address 16 with DEPTH=16 -> O_illegal=1.
- WRITE 0xDEADBEEF to addr 3, then SET 0x000000F0, then CLEAR 0x0000000F:
  - acks return 0, 0xDEADBEEF, 0xDEADBEFF in that order;
  - final debug read = 0xDEADBEF0.
- RO_MASK bit 5 set:
  - WRITE addr 5 -> illegal, value unchanged;
  - SET addr 5 wdata 0 -> legal, O_rdata=RST_VAL.
- Back-to-back I_req held high for 6 cycles -> exactly 3 acks, none in consecutive cycles.
- Assert I_rst in the RESP cycle of a WRITE -> no ack, entry = RST_VAL.
- CSR_CYCLE_COUNTER_EN defined:
  - two READs of addr 0 issued 4 cycles apart -> O_rdata differs by 4;
  - WRITE addr 0 -> illegal;
  - counter preloaded to all-ones by force -> reads 0 next cycle.
